// File: rtl/grid_reader.sv
// Purpose : reads single cells of a 16x16 2-bit game grid. It can also sweep the whole
//           grid and count the snake cells and the food cells.
// Latency : a query result appears 2 cycles after the accept edge. scan_done pulses
//           257 cycles after the scan accept edge.
// Backpr. : query_ready is high only in IDLE. Requests seen outside IDLE are ignored.
//           A query wins over a scan_start in the same cycle, and that scan_start is dropped.
// Ports   : clk/reset (sync, active-low); query_valid/query_x/query_y/query_ready;
//           rd_x/rd_y/rd_data to the grid memory (1-cycle read);
//           result_valid/result_data/hit_snake/hit_food; scan_start/scan_done/
//           snake_count/food_count.
// Config  : define GRID_READER_SCAN_EN to build the SCAN sweep and the counters. Without it,
//           scan_start is ignored and scan_done and the counts are tied to 0.
module grid_reader #(
    parameter logic [1:0] SNAKE_CODE = 2'b01,
    parameter logic [1:0] FOOD_CODE  = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       query_valid,
    input  logic [3:0] query_x,
    input  logic [3:0] query_y,
    output logic       query_ready,
    output logic [3:0] rd_x,
    output logic [3:0] rd_y,
    input  logic [1:0] rd_data,
    output logic       result_valid,
    output logic [1:0] result_data,
    output logic       hit_snake,
    output logic       hit_food,
    input  logic       scan_start,
    output logic       scan_done,
    output logic [8:0] snake_count,
    output logic [8:0] food_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        Q_RD  = 2'd1,
        Q_RSP = 2'd2
`ifdef GRID_READER_SCAN_EN
        ,
        SCAN  = 2'd3
`endif
    } state_t;

    state_t state;

`ifdef GRID_READER_SCAN_EN
    // Counts SCAN cycles from 0 to 256.
    // Cycle k issues address k for k <= 255, and counts the data of cell k-1 for k >= 1.
    logic [8:0] scan_cnt;
`else
    logic unused_scan_start;
    assign unused_scan_start = scan_start;
    assign scan_done         = 1'b0;
    assign snake_count       = 9'd0;
    assign food_count        = 9'd0;
`endif

    assign query_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rd_x         <= 4'd0;
            rd_y         <= 4'd0;
            result_valid <= 1'b0;
            result_data  <= 2'b00;
            hit_snake    <= 1'b0;
            hit_food     <= 1'b0;
`ifdef GRID_READER_SCAN_EN
            scan_done    <= 1'b0;
            snake_count  <= 9'd0;
            food_count   <= 9'd0;
            scan_cnt     <= 9'd0;
`endif
        end else begin
            result_valid <= 1'b0;
`ifdef GRID_READER_SCAN_EN
            scan_done    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (query_valid) begin
                        rd_x  <= query_x;
                        rd_y  <= query_y;
                        state <= Q_RD;
                    end
`ifdef GRID_READER_SCAN_EN
                    else if (scan_start) begin
                        rd_x        <= 4'd0;
                        rd_y        <= 4'd0;
                        snake_count <= 9'd0;
                        food_count  <= 9'd0;
                        scan_cnt    <= 9'd0;
                        state       <= SCAN;
                    end
`endif
                end
                // The memory returns data one cycle after the address changes.
                Q_RD: state <= Q_RSP;
                Q_RSP: begin
                    result_data  <= rd_data;
                    hit_snake    <= (rd_data == SNAKE_CODE);
                    hit_food     <= (rd_data == FOOD_CODE);
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
`ifdef GRID_READER_SCAN_EN
                SCAN: begin
                    scan_cnt <= scan_cnt + 9'd1;
                    // With x in the low nibble, the linear index steps x fastest.
                    // The address stops at 15/15 after the last cell.
                    if (scan_cnt < 9'd255)
                        {rd_y, rd_x} <= scan_cnt[7:0] + 8'd1;
                    if (scan_cnt != 9'd0) begin
                        if (rd_data == SNAKE_CODE)
                            snake_count <= snake_count + 9'd1;
                        if (rd_data == FOOD_CODE)
                            food_count <= food_count + 9'd1;
                    end
                    // Cycle 256 is the drain cycle for the data of cell 255.
                    if (scan_cnt == 9'd256) begin
                        scan_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_reader.sv
// Bench for grid_reader. A grid array models the memory and serves as the reference.
// Expected results are queued when a request is issued. A negedge monitor pops the queue and compares.
module tb_grid_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       query_valid;
    logic [3:0] query_x;
    logic [3:0] query_y;
    logic       query_ready;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic [1:0] rd_data;
    logic       result_valid;
    logic [1:0] result_data;
    logic       hit_snake;
    logic       hit_food;
    logic       scan_start;
    logic       scan_done;
    logic [8:0] snake_count;
    logic [8:0] food_count;

    always #5 clk = ~clk;

    grid_reader dut (
        .clk          (clk),
        .reset        (reset),
        .query_valid  (query_valid),
        .query_x      (query_x),
        .query_y      (query_y),
        .query_ready  (query_ready),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_data      (rd_data),
        .result_valid (result_valid),
        .result_data  (result_data),
        .hit_snake    (hit_snake),
        .hit_food     (hit_food),
        .scan_start   (scan_start),
        .scan_done    (scan_done),
        .snake_count  (snake_count),
        .food_count   (food_count)
    );

    // Grid memory: the data for an address arrives one cycle after the address.
    logic [1:0] mem [256];
    always @(posedge clk) rd_data <= mem[{rd_y, rd_x}];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] data; int at; } qexp_t;
    typedef struct { int snake; int food; int at; } sexp_t;
    qexp_t qq[$];
    sexp_t sq[$];
    qexp_t qe;
    sexp_t se;
    logic [1:0] last_data;
    bit have_last = 0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            have_last = 0;
        end else begin
            if (result_valid) begin
                if (qq.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    qe = qq.pop_front();
                    check("result_cycle", cyc, qe.at);
                    check("result_data", result_data, qe.data);
                    check("hit_snake", hit_snake, int'(qe.data == 2'b01));
                    check("hit_food", hit_food, int'(qe.data == 2'b10));
                    last_data = qe.data;
                    have_last = 1;
                end
            end else begin
                if (have_last) check("result_hold", result_data, last_data);
                if (qq.size() != 0 && cyc > qq[0].at) begin
                    check("result_missing", 0, 1);
                    void'(qq.pop_front());
                end
            end
`ifdef GRID_READER_SCAN_EN
            if (scan_done) begin
                if (sq.size() == 0) check("unexpected_scan_done", 1, 0);
                else begin
                    se = sq.pop_front();
                    check("scan_done_cycle", cyc, se.at);
                    check("snake_count", snake_count, se.snake);
                    check("food_count", food_count, se.food);
                end
            end else if (sq.size() != 0 && cyc > sq[0].at) begin
                check("scan_done_missing", 0, 1);
                void'(sq.pop_front());
            end
`else
            check("scan_done_tied", scan_done, 0);
            check("snake_count_tied", snake_count, 0);
            check("food_count_tied", food_count, 0);
`endif
        end
    end

    task automatic wait_ready(output int gap);
        gap = 0;
        while (!query_ready && gap < 400) begin
            tick();
            gap++;
        end
        if (gap >= 400) check("ready_timeout", 0, 1);
    endtask

    task automatic do_query(input logic [3:0] x, input logic [3:0] y, input bit hold,
                            output int gap);
        qexp_t e;
        wait_ready(gap);
        query_x     = x;
        query_y     = y;
        query_valid = 1'b1;
        e.data = mem[{y, x}];
        e.at   = cyc + 3;
        qq.push_back(e);
        tick();
        check("accept_rd_addr", {rd_y, rd_x}, {y, x});
        check("busy_ready_low", query_ready, 0);
        if (!hold) query_valid = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_ready", query_ready, 1);
        check("rst_rd_addr", {rd_y, rd_x}, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_data", result_data, 0);
        check("rst_flags", {hit_snake, hit_food}, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_counts", {snake_count, food_count}, 0);
    endtask

    task automatic do_reset();
        qq.delete();
        sq.delete();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset_state();
    endtask

    task automatic do_scan(input int abort_at);
        int s, f, gap;
        sexp_t e;
        s = 0;
        f = 0;
        query_valid = 1'b0;
        wait_ready(gap);
        for (int i = 0; i < 256; i++) begin
            if (mem[i] == 2'b01) s++;
            else if (mem[i] == 2'b10) f++;
        end
        scan_start = 1'b1;
        e.snake = s;
        e.food  = f;
        e.at    = cyc + 1 + 257;
`ifdef GRID_READER_SCAN_EN
        sq.push_back(e);
`endif
        tick();
        scan_start = 1'b0;
        for (int k = 0; k <= 257; k++) begin
            if (k == abort_at) begin
                do_reset();
                return;
            end
`ifdef GRID_READER_SCAN_EN
            check("scan_addr", {rd_y, rd_x}, (k > 255) ? 255 : k);
`endif
            tick();
        end
`ifdef GRID_READER_SCAN_EN
        check("snake_count_hold", snake_count, s);
        check("food_count_hold", food_count, f);
`else
        check("scan_disabled_counts", {snake_count, food_count}, 0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 256; i++) mem[i] = (v < 0) ? 2'($urandom_range(0, 3)) : 2'(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        int gap;
        reset       = 1'b0;
        query_valid = 1'b0;
        scan_start  = 1'b0;
        query_x     = 4'd0;
        query_y     = 4'd0;
        fill(0);
        idle(3);
        check_reset_state();
        reset = 1'b1;
        tick();
        check("ready_after_release", query_ready, 1);

        // Single query of a snake cell.
        mem[{4'd5, 4'd3}] = 2'b01;
        do_query(4'd3, 4'd5, 1'b0, gap);
        idle(4);

        // Back-to-back queries with query_valid held high.
        mem[0]   = 2'b10;
        mem[255] = 2'b00;
        do_query(4'd0, 4'd0, 1'b1, gap);
        do_query(4'd15, 4'd15, 1'b1, gap);
        check("b2b_ready_gap", gap, 2);
        query_valid = 1'b0;
        idle(4);

        // Scan of a mixed grid, including one cell of code 11.
        fill(0);
        mem[3] = 2'b01; mem[17] = 2'b01; mem[128] = 2'b01; mem[255] = 2'b01;
        mem[0] = 2'b10; mem[77] = 2'b11;
        do_scan(-1);

        // Full grid of snake cells: 256 must not wrap.
        fill(1);
        do_scan(-1);
        do_query(4'd7, 4'd9, 1'b0, gap);
        idle(4);

        // Simultaneous query and scan_start: the query wins and the scan is dropped.
        fill(-1);
        wait_ready(gap);
        query_x = 4'd12; query_y = 4'd1;
        query_valid = 1'b1;
        scan_start  = 1'b1;
        qe.data = mem[{4'd1, 4'd12}];
        qe.at   = cyc + 3;
        qq.push_back(qe);
        tick();
        query_valid = 1'b0;
        scan_start  = 1'b0;
        idle(300);

        // Randomized queries, grid refills and scans.
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) begin
                query_valid = 1'b0;
                idle(3);
                fill(-1);
            end else if (r == 1) begin
                do_scan(-1);
            end else begin
                do_query(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), gap);
            end
        end
        query_valid = 1'b0;
        idle(5);

        // A reset in the middle of a scan aborts it, with no scan_done.
        fill(1);
        do_query(4'd2, 4'd2, 1'b0, gap);
        idle(4);
        do_scan(100);
        idle(300);
        do_query(4'd4, 4'd6, 1'b0, gap);
        idle(5);

        check("queues_drained", qq.size() + sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grid_reader.md
GRID_READER -- requirements
Module: grid_reader

Interface
REQ-001 Parameter SNAKE_CODE, default 2'b01, is the grid cell code for a snake segment.
REQ-002 Parameter FOOD_CODE, default 2'b10, is the grid cell code for food; 2'b00 means empty, and any other code counts as neither.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 query_valid  in  1  requests a single-cell read.
REQ-006 query_x, query_y  in  4 each  coordinates of the queried cell.
REQ-007 query_ready  out  1  high when a query or scan can be accepted.
REQ-008 rd_x, rd_y  out  4 each  registered read address to the grid memory.
REQ-009 rd_data  in  2  grid memory read data, valid exactly one cycle after rd_x/rd_y change.
REQ-010 result_valid  out  1  one-cycle pulse marking a query result.
REQ-011 result_data  out  2  raw cell code of the queried cell.
REQ-012 hit_snake, hit_food  out  1 each  decoded result flags, valid with result_valid.
REQ-013 scan_start  in  1  requests a full 16x16 occupancy sweep.
REQ-014 scan_done  out  1  one-cycle pulse when the sweep counts are final.
REQ-015 snake_count, food_count  out  9 each  cells matching SNAKE_CODE/FOOD_CODE, range 0..256.

Function
REQ-016 The FSM SHALL have the states IDLE, Q_RD, Q_RSP and SCAN; query_ready SHALL be 1 only in IDLE.
REQ-017 Query accept: on the edge with IDLE & query_valid, rd_x/rd_y SHALL load query_x/query_y and the state SHALL go to Q_RD.
REQ-018 In Q_RD, the block SHALL wait one cycle for rd_data and then go to Q_RSP.
REQ-019 In Q_RSP, the block SHALL register rd_data into result_data, set the flags, pulse result_valid for exactly one cycle and return to IDLE; result_valid is high in the second cycle after the accept edge.
REQ-020 hit_snake SHALL equal (result_data==SNAKE_CODE) and hit_food SHALL equal (result_data==FOOD_CODE); result_data and the flags SHALL hold until the next result.
REQ-021 Scan accept: on the edge with IDLE & scan_start & !query_valid, the counts SHALL clear to 0, rd_x/rd_y SHALL go to 0/0, and the state SHALL go to SCAN.
REQ-022 In SCAN, the address SHALL advance one cell per cycle, x fastest (x 0..15, then y+1), covering all 256 cells with no repeats and no gaps.
REQ-023 Each cycle, rd_data from the address issued the previous cycle SHALL be compared and the matching count incremented; the counts SHALL be 9 bits wide so that 256 does not wrap.
REQ-024 After the last address (15,15) plus one drain cycle, scan_done SHALL pulse for one cycle, exactly 257 cycles after the scan accept edge, and the state SHALL return to IDLE.
REQ-025 After x=15,y=15 the address SHALL not wrap into a second sweep; rd_x/rd_y SHALL hold 15/15 until the next accept.
REQ-026 If query_valid and scan_start are both high in IDLE, the query SHALL win and scan_start SHALL be dropped, not queued.
REQ-027 query_valid and scan_start SHALL be ignored outside IDLE.
REQ-028 The counts SHALL hold their final values from scan_done until the next scan accept or reset.

Reset
REQ-029 With reset==0 at a clock edge: state=IDLE; rd_x=rd_y=0; result_valid=0; result_data=0; hit_snake=hit_food=0; scan_done=0; snake_count=food_count=0.
REQ-030 A reset during Q_RD, Q_RSP or SCAN SHALL abort the operation with no result_valid and no scan_done pulse; query_ready SHALL be 1 in the first cycle after reset releases.

Configuration
REQ-031 Macro GRID_READER_SCAN_EN defined: SCAN state, address sweep and counters SHALL be compiled in as above.
REQ-032 Macro GRID_READER_SCAN_EN undefined: there SHALL be no SCAN state; scan_start is ignored; scan_done, snake_count and food_count are tied to 0; query behaviour is unchanged.

Verification
REQ-033 Query: memory (3,5)=01; query_valid with (3,5) -> rd_x=3, rd_y=5 after accept; result_valid in the 2nd cycle after accept; result_data=01, hit_snake=1, hit_food=0.
REQ-034 Back-to-back queries with query_valid held high: (0,0)=10, then (15,15)=00 -> query_ready low for 2 cycles between accepts; results 10/hit_food=1, then 00/both flags 0.
REQ-035 Scan: grid holds 4 snake cells, 1 food cell and 1 cell of code 11 -> scan_done 257 cycles after accept; snake_count=4, food_count=1; the 11 cell is counted nowhere.
REQ-036 Full grid: all 256 cells=01 -> snake_count=256 (9'h100), food_count=0, no wrap.
REQ-037 scan_start and query_valid asserted together in IDLE -> only the query runs; no scan_done follows.
REQ-038 reset driven low at cycle 100 of a scan -> no scan_done, counts=0, query_ready=1 in the first cycle after release; a rebuild without GRID_READER_SCAN_EN gives scan_done=0 and counts=0 forever.
